// File: rtl/sound_pkg.sv
// Shared tone/channel codes and sequencer state encoding, also used by soundCard users.
package sound_pkg;

  localparam logic [1:0] SND_NONE = 2'd0;
  localparam logic [1:0] SND_PING = 2'd1;
  localparam logic [1:0] SND_PONG = 2'd2;
  localparam logic [1:0] SND_GOAL = 2'd3;

  localparam logic [1:0] CH_NONE  = 2'd0;
  localparam logic [1:0] CH_RIGHT = 2'd1;
  localparam logic [1:0] CH_LEFT  = 2'd2;
  localparam logic [1:0] CH_BOTH  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One-hot position of a tone in the {goal, pong, ping} request/pending vectors.
  function automatic logic [2:0] tone_mask(input logic [1:0] tone);
    case (tone)
      SND_PING: return 3'b001;
      SND_PONG: return 3'b010;
      SND_GOAL: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  // Highest-priority pending tone: goal > pong > ping.
  function automatic logic [1:0] pick_tone(input logic [2:0] pend);
    if (pend[2])      return SND_GOAL;
    else if (pend[1]) return SND_PONG;
    else if (pend[0]) return SND_PING;
    else              return SND_NONE;
  endfunction

endpackage

// File: rtl/sound_timer.sv
// Loadable down-counter that stops at zero; done flags the end of a phase.
module sound_timer
#(
  parameter int CW = 24
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          done
);

  logic [CW-1:0] count_q, count_d;

  // Load wins; otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load)                count_d = value;
    else if (count_q != '0)  count_d = count_q - CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/sound_sequencer.sv
// Queues ping/pong/goal requests and plays them as timed tones with silent gaps.
// Optional feature: define SOUND_SEQUENCER_GOAL_REPEAT_EN to play each goal three times.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned DUR_PING = 2500000,
  parameter int unsigned DUR_PONG = 2500000,
  parameter int unsigned DUR_GOAL = 12500000,
  parameter int unsigned GAP      = 250000,
  parameter int          CW       = 24
)(
  input  logic       snd_clk,
  input  logic       rst,
  input  logic       req_ping,
  input  logic       req_pong,
  input  logic       req_goal,
  input  logic [1:0] req_chan,
  output logic [1:0] sound,
  output logic [1:0] channel,
  output logic       busy
);

  localparam logic [CW-1:0] LD_PING = CW'(DUR_PING - 1);
  localparam logic [CW-1:0] LD_PONG = CW'(DUR_PONG - 1);
  localparam logic [CW-1:0] LD_GOAL = CW'(DUR_GOAL - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'(GAP - 1);

  function automatic logic [CW-1:0] dur_ld(input logic [1:0] tone);
    case (tone)
      SND_PING: return LD_PING;
      SND_PONG: return LD_PONG;
      default:  return LD_GOAL;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  sound_q, sound_d;
  logic [1:0]  channel_q, channel_d;
  logic [2:0]  pend_q, pend_d;
  logic [1:0]  ping_ch_q, ping_ch_d;
  logic [1:0]  pong_ch_q, pong_ch_d;
  logic [1:0]  goal_ch_q, goal_ch_d;
`ifdef SOUND_SEQUENCER_GOAL_REPEAT_EN
  logic [1:0]  rep_q, rep_d;
  logic        rep_cont;
`endif

  logic [2:0]    req_vec;
  logic [2:0]    clr, cons;
  logic          start;
  logic [1:0]    start_tone, start_ch;
  logic [1:0]    disp_tone, disp_ch;
  logic          tmr_load, tmr_done;
  logic [CW-1:0] tmr_val;

  assign req_vec = {req_goal, req_pong, req_ping};

  sound_timer #(.CW(CW)) u_timer (
    .clk   (snd_clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  // Next-state logic: dispatch, preemption/retrigger, phase sequencing and pending bookkeeping.
  always_comb begin
    state_d    = state_q;
    sound_d    = sound_q;
    channel_d  = channel_q;
    ping_ch_d  = req_ping ? req_chan : ping_ch_q;
    pong_ch_d  = req_pong ? req_chan : pong_ch_q;
    goal_ch_d  = req_goal ? req_chan : goal_ch_q;
    clr        = 3'b000;
    cons       = 3'b000;
    start      = 1'b0;
    start_tone = SND_NONE;
    start_ch   = CH_NONE;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    disp_tone  = pick_tone(pend_q);
    case (disp_tone)
      SND_GOAL: disp_ch = goal_ch_q;
      SND_PONG: disp_ch = pong_ch_q;
      default:  disp_ch = ping_ch_q;
    endcase
`ifdef SOUND_SEQUENCER_GOAL_REPEAT_EN
    rep_d    = rep_q;
    rep_cont = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          start      = 1'b1;
          start_tone = disp_tone;
          start_ch   = disp_ch;
          clr        = tone_mask(disp_tone);
        end
      end
      ST_PLAY: begin
        if (req_goal && (sound_q != SND_GOAL)) begin
          // Goal cuts the current tone short; the cut tone is dropped.
          start      = 1'b1;
          start_tone = SND_GOAL;
          start_ch   = req_chan;
          cons       = 3'b100;
        end else if (|(req_vec & tone_mask(sound_q))) begin
          // Same tone requested again: restart it on the new channel.
          start      = 1'b1;
          start_tone = sound_q;
          start_ch   = req_chan;
          cons       = tone_mask(sound_q);
        end else if (tmr_done) begin
          state_d   = ST_GAP;
          sound_d   = SND_NONE;
          channel_d = CH_NONE;
          tmr_load  = 1'b1;
          tmr_val   = LD_GAP;
`ifdef SOUND_SEQUENCER_GOAL_REPEAT_EN
          if (sound_q == SND_GOAL) rep_d = rep_q - 2'd1;
`endif
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
`ifdef SOUND_SEQUENCER_GOAL_REPEAT_EN
          // Remaining goal repeats go ahead of pong/ping; a fresh goal request restarts the count.
          if ((rep_q != 2'd0) && !pend_q[2]) begin
            start      = 1'b1;
            start_tone = SND_GOAL;
            start_ch   = goal_ch_q;
            rep_cont   = 1'b1;
          end else
`endif
          if (|pend_q) begin
            start      = 1'b1;
            start_tone = disp_tone;
            start_ch   = disp_ch;
            clr        = tone_mask(disp_tone);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d   = ST_PLAY;
      sound_d   = start_tone;
      channel_d = start_ch;
      tmr_load  = 1'b1;
      tmr_val   = dur_ld(start_tone);
`ifdef SOUND_SEQUENCER_GOAL_REPEAT_EN
      if ((start_tone == SND_GOAL) && !rep_cont) rep_d = 2'd3;
`endif
    end

    pend_d = (pend_q & ~clr) | (req_vec & ~cons);
  end

  // State, output and request registers.
  always_ff @(posedge snd_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sound_q   <= SND_NONE;
      channel_q <= CH_NONE;
      pend_q    <= 3'b000;
      ping_ch_q <= CH_NONE;
      pong_ch_q <= CH_NONE;
      goal_ch_q <= CH_NONE;
`ifdef SOUND_SEQUENCER_GOAL_REPEAT_EN
      rep_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      sound_q   <= sound_d;
      channel_q <= channel_d;
      pend_q    <= pend_d;
      ping_ch_q <= ping_ch_d;
      pong_ch_q <= pong_ch_d;
      goal_ch_q <= goal_ch_d;
`ifdef SOUND_SEQUENCER_GOAL_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign sound   = sound_q;
  assign channel = channel_q;
  assign busy    = (state_q != ST_IDLE) || (|pend_q);

endmodule
